pio_in_debounce_irq: RTL and testbench

Parametrised Avalon-MM input PIO: the successor of the fixed-width read-only input port used for screen/status codes. Synchronises and debounces up to 32 external input bits and exposes data, interrupt mask, edge-capture and raw registers on a 2-bit slave address. It raises a level interrupt on configurable edges. It sits between board pins (buttons, switches, robot status lines) and the Nios II system interconnect.

---
 rtl/pio_in_debounce_irq.sv | 153 +++++++++++++++
 tb/tb_pio_in_debounce_irq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input PIO: synchronised, debounced inputs with edge capture and
// a masked level interrupt. Registers: 0 data, 1 irq_mask, 2 edge_capture
// (write-1-to-clear), 3 synchronised raw input.
module pio_in_debounce_irq #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MASK = 2'd1,
    REG_EDGE = 2'd2,
    REG_RAW  = 2'd3
  } reg_addr_e;

  localparam edge_mode_e  MODE     = edge_mode_e'(EDGE_MODE[1:0]);
  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edge_ev;

  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;

  // Upper writedata bits are architecturally ignored when WIDTH < 32.
  logic [31:0]      wdata_unused;
  assign wdata_unused = writedata;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign readdata = readdata_q;
  assign irq      = irq_q;

  // Synchroniser shift chain
  always_comb begin
    sync_d[0] = in_port;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES disagreeing cycles
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge events qualified by the configured edge mode
  always_comb begin
    case (MODE)
      EDGE_FALL: edge_ev = deb_q & ~deb_d;
      EDGE_ANY:  edge_ev = deb_q ^ deb_d;
      default:   edge_ev = deb_d & ~deb_q;
    endcase
  end

  // Register writes, edge capture, irq and read mux.
  // Read mux and irq use current register contents, so a same-cycle write is
  // not visible until the following read.
  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    if (write) begin
      case (reg_addr_e'(address))
        REG_MASK: mask_d = writedata[WIDTH-1:0];
        REG_EDGE: clr    = writedata[WIDTH-1:0];
        default:  ;
      endcase
    end
    cap_d = (cap_q & ~clr) | edge_ev;
    irq_d = |(cap_q & mask_q);
    readdata_d = '0;
    case (reg_addr_e'(address))
      REG_DATA: readdata_d[WIDTH-1:0] = deb_q;
      REG_MASK: readdata_d[WIDTH-1:0] = mask_q;
      REG_EDGE: readdata_d[WIDTH-1:0] = cap_q;
      default:  readdata_d[WIDTH-1:0] = sync_out;
    endcase
  end

  // Input path state: synchroniser, debounce counters, debounced value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      deb_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  // Register file and bus-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Self-checking bench for pio_in_debounce_irq: three instances (defaults,
// falling-edge mode, wide/fast configuration) plus a window-based reference
// model of the default instance driven with random traffic.
module tb_pio_in_debounce_irq;

  localparam int M_S = 2;
  localparam int M_D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: defaults (rising edge)
  logic [1:0]  addr0;
  logic        wr0;
  logic [31:0] wd0;
  logic [31:0] rd0;
  logic [4:0]  in0;
  logic        irq0;

  // Instance 1: falling edge
  logic [1:0]  addr1;
  logic        wr1;
  logic [31:0] wd1;
  logic [31:0] rd1;
  logic [4:0]  in1;
  logic        irq1;

  // Instance 2: 32 bits, 3 sync stages, 1-cycle debounce, any edge
  logic [1:0]  addr2;
  logic        wr2;
  logic [31:0] wd2;
  logic [31:0] rd2;
  logic [31:0] in2;
  logic        irq2;

  pio_in_debounce_irq #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(addr0), .write(wr0), .writedata(wd0),
    .readdata(rd0), .in_port(in0), .irq(irq0));

  pio_in_debounce_irq #(.WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .address(addr1), .write(wr1), .writedata(wd1),
    .readdata(rd1), .in_port(in1), .irq(irq1));

  pio_in_debounce_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .address(addr2), .write(wr2), .writedata(wd2),
    .readdata(rd2), .in_port(in2), .irq(irq2));

  // Reference model of instance 0
  logic [4:0]  m_in_hist[$];
  logic [4:0]  m_sync_hist[$];
  logic [4:0]  m_deb;
  logic [4:0]  m_cap;
  logic [4:0]  m_mask;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic model_reset();
    m_in_hist.delete();
    m_sync_hist.delete();
    for (int k = 0; k < M_S; k++) m_in_hist.push_back(5'd0);
    for (int k = 0; k < M_D; k++) m_sync_hist.push_back(5'd0);
    m_deb  = '0;
    m_cap  = '0;
    m_mask = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
  endtask

  // A bit's debounced value flips once the synchronised input has disagreed
  // with it for the last M_D consecutive clock edges.
  task automatic model_step();
    logic [4:0] sync_pre;
    logic [4:0] new_deb;
    logic [4:0] ev;
    logic [4:0] clr;
    int         n_diff;
    sync_pre = m_in_hist[M_S-1];
    m_in_hist.push_front(in0);
    void'(m_in_hist.pop_back());
    m_sync_hist.push_front(sync_pre);
    void'(m_sync_hist.pop_back());
    new_deb = m_deb;
    for (int b = 0; b < 5; b++) begin
      n_diff = 0;
      for (int k = 0; k < M_D; k++) begin
        if (m_sync_hist[k][b] != m_deb[b]) n_diff++;
      end
      if (n_diff == M_D) new_deb[b] = ~m_deb[b];
    end
    ev  = new_deb & ~m_deb;
    clr = (wr0 && addr0 == 2'd2) ? wd0[4:0] : 5'd0;
    case (addr0)
      2'd0:    m_rd = {27'd0, m_deb};
      2'd1:    m_rd = {27'd0, m_mask};
      2'd2:    m_rd = {27'd0, m_cap};
      default: m_rd = {27'd0, sync_pre};
    endcase
    m_irq = |(m_cap & m_mask);
    m_cap = (m_cap & ~clr) | ev;
    if (wr0 && addr0 == 2'd1) m_mask = wd0[4:0];
    m_deb = new_deb;
  endtask

  // One clock: model advances on the edge, outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    addr0 = '0; wr0 = 1'b0; wd0 = '0;
    addr1 = '0; wr1 = 1'b0; wd1 = '0;
    addr2 = '0; wr2 = 1'b0; wd2 = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in0 = '0; in1 = '0; in2 = '0;
    do_reset();
    in0 = 5'h1F;
    repeat (4) cycle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (rd0 !== 32'd0 || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async0: rd=%h irq=%b expected rd=0 irq=0", rd0, irq0);
    end
    n_checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || irq1 !== 1'b0 || irq2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async12: rd1=%h rd2=%h expected 0", rd1, rd2);
    end
    model_reset();
    @(negedge clk);
    cycle();
    n_checks++;
    if (rd0 !== 32'd0 || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: rd=%h irq=%b expected rd=0 irq=0", rd0, irq0);
    end
    reset = 1'b0;
    addr0 = 2'd3;
    cycle();
    cycle();
    n_checks++;
    if (rd0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_raw_e2: got %h expected %h", rd0, 32'd0);
    end
    cycle();
    n_checks++;
    if (rd0 !== 32'h1F) begin
      n_fail++; $display("FAIL reset_raw_e3: got %h expected %h", rd0, 32'h1F);
    end
    addr0 = 2'd0;
    repeat (3) cycle();
    n_checks++;
    if (rd0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_data_e6: got %h expected %h", rd0, 32'd0);
    end
    cycle();
    n_checks++;
    if (rd0 !== 32'h1F) begin
      n_fail++; $display("FAIL reset_data_e7: got %h expected %h", rd0, 32'h1F);
    end
    addr0 = 2'd2;
    cycle();
    n_checks++;
    if (rd0 !== 32'h1F || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_capture: rd=%h irq=%b expected rd=1f irq=0", rd0, irq0);
    end
    addr0 = 2'd1;
    cycle();
    n_checks++;
    if (rd0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_mask: got %h expected %h", rd0, 32'd0);
    end
  endtask

  task automatic test_debounce_filter();
    in0 = '0;
    do_reset();
    addr0 = 2'd0;
    in0 = 5'h01;
    for (int e = 1; e <= 11; e++) begin
      if (e == 4) in0 = 5'h00;
      cycle();
      n_checks++;
      if (rd0 !== 32'd0) begin
        n_fail++; $display("FAIL filter_pulse e%0d: got %h expected %h", e, rd0, 32'd0);
      end
    end
    in0 = 5'h02;
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e >= 5) begin
        n_checks++;
        if (rd0 !== ((e == 7) ? 32'h02 : 32'h00)) begin
          n_fail++; $display("FAIL filter_hold e%0d: got %h expected %h", e, rd0, (e == 7) ? 32'h02 : 32'h00);
        end
      end
    end
  endtask

  task automatic test_glitch_restart();
    in0 = '0;
    do_reset();
    addr0 = 2'd0;
    for (int e = 1; e <= 11; e++) begin
      in0 = (e == 4) ? 5'h00 : 5'h04;
      cycle();
      if (e >= 7) begin
        n_checks++;
        if (rd0 !== ((e == 11) ? 32'h04 : 32'h00)) begin
          n_fail++; $display("FAIL glitch e%0d: got %h expected %h", e, rd0, (e == 11) ? 32'h04 : 32'h00);
        end
      end
    end
  endtask

  task automatic test_edge_modes();
    in1 = '0;
    do_reset();
    addr1 = 2'd1; wr1 = 1'b1; wd1 = 32'h01;
    cycle();
    wr1 = 1'b0; addr1 = 2'd2;
    in1 = 5'h01;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (e >= 6) begin
        n_checks++;
        if (rd1 !== 32'd0 || irq1 !== 1'b0) begin
          n_fail++; $display("FAIL fall_mode_rise e%0d: rd=%h irq=%b expected rd=0 irq=0", e, rd1, irq1);
        end
      end
    end
    in1 = 5'h00;
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e >= 6) begin
        n_checks++;
        if (rd1 !== ((e == 7) ? 32'h01 : 32'h00) || irq1 !== (e == 7)) begin
          n_fail++; $display("FAIL fall_mode_fall e%0d: rd=%h irq=%b expected rd=%h irq=%b",
                             e, rd1, irq1, (e == 7) ? 32'h01 : 32'h00, e == 7);
        end
      end
    end
    wr1 = 1'b1; wd1 = 32'h01;
    cycle();
    wr1 = 1'b0;
    n_checks++;
    if (rd1 !== 32'h01 || irq1 !== 1'b1) begin
      n_fail++; $display("FAIL clear_cycle: rd=%h irq=%b expected rd=01 irq=1", rd1, irq1);
    end
    cycle();
    n_checks++;
    if (rd1 !== 32'h00 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL clear_after: rd=%h irq=%b expected rd=0 irq=0", rd1, irq1);
    end
  endtask

  task automatic test_simultaneous();
    in0 = '0;
    do_reset();
    addr0 = 2'd2;
    in0 = 5'h08;
    repeat (7) cycle();
    n_checks++;
    if (rd0 !== 32'h08 || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL simul_first_capture: rd=%h irq=%b expected rd=08 irq=0", rd0, irq0);
    end
    addr0 = 2'd1; wr0 = 1'b1; wd0 = 32'h08;
    cycle();
    wr0 = 1'b0; addr0 = 2'd2;
    n_checks++;
    if (irq0 !== 1'b0) begin
      n_fail++; $display("FAIL mask_write_cycle: irq=%b expected 0", irq0);
    end
    cycle();
    n_checks++;
    if (irq0 !== 1'b1) begin
      n_fail++; $display("FAIL mask_write_next: irq=%b expected 1", irq0);
    end
    in0 = 5'h00;
    repeat (8) cycle();
    n_checks++;
    if (rd0 !== 32'h08 || irq0 !== 1'b1) begin
      n_fail++; $display("FAIL simul_fall_no_event: rd=%h irq=%b expected rd=08 irq=1", rd0, irq0);
    end
    in0 = 5'h08;
    repeat (5) cycle();
    wr0 = 1'b1; wd0 = 32'h08;
    cycle();
    wr0 = 1'b0;
    for (int e = 7; e <= 8; e++) begin
      cycle();
      n_checks++;
      if (rd0 !== 32'h08 || irq0 !== 1'b1) begin
        n_fail++; $display("FAIL simul_set_wins e%0d: rd=%h irq=%b expected rd=08 irq=1", e, rd0, irq0);
      end
    end
    addr0 = 2'd0;
    cycle();
    n_checks++;
    if (rd0 !== 32'h08) begin
      n_fail++; $display("FAIL simul_deb: got %h expected %h", rd0, 32'h08);
    end
    addr0 = 2'd2; wr0 = 1'b1; wd0 = 32'h08;
    cycle();
    wr0 = 1'b0;
    cycle();
    n_checks++;
    if (rd0 !== 32'h00 || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL simul_plain_clear: rd=%h irq=%b expected rd=0 irq=0", rd0, irq0);
    end
  endtask

  task automatic test_param();
    in2 = '0;
    do_reset();
    addr2 = 2'd2;
    in2 = 32'h8000_0000;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e >= 4) begin
        n_checks++;
        if (rd2 !== ((e == 5) ? 32'h8000_0000 : 32'h0)) begin
          n_fail++; $display("FAIL wide_rise e%0d: got %h expected %h", e, rd2, (e == 5) ? 32'h8000_0000 : 32'h0);
        end
      end
    end
    wr2 = 1'b1; wd2 = 32'h8000_0000;
    cycle();
    wr2 = 1'b0;
    cycle();
    n_checks++;
    if (rd2 !== 32'h0) begin
      n_fail++; $display("FAIL wide_clear: got %h expected %h", rd2, 32'h0);
    end
    in2 = 32'h0;
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e >= 4) begin
        n_checks++;
        if (rd2 !== ((e == 5) ? 32'h8000_0000 : 32'h0) || irq2 !== 1'b0) begin
          n_fail++; $display("FAIL wide_fall e%0d: rd=%h irq=%b expected rd=%h irq=0",
                             e, rd2, irq2, (e == 5) ? 32'h8000_0000 : 32'h0);
        end
      end
    end
  endtask

  task automatic test_random();
    in0 = '0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(5) == 0) in0 = in0 ^ 5'($urandom_range(31, 1));
      addr0 = 2'($urandom_range(3));
      wr0   = ($urandom_range(7) == 0);
      wd0   = $urandom;
      cycle();
      n_checks++;
      if (rd0 !== m_rd || irq0 !== m_irq) begin
        n_fail++; $display("FAIL random n%0d: rd=%h irq=%b expected rd=%h irq=%b", n, rd0, irq0, m_rd, m_irq);
      end
    end
    wr0 = 1'b0;
  endtask

  initial begin
    addr0 = '0; wr0 = 1'b0; wd0 = '0; in0 = '0;
    addr1 = '0; wr1 = 1'b0; wd1 = '0; in1 = '0;
    addr2 = '0; wr2 = 1'b0; wd2 = '0; in2 = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_debounce_filter();
    test_glitch_restart();
    test_edge_modes();
    test_simultaneous();
    test_param();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
